// File: rtl/udp_prg_loader_pkg.sv
// rtl/udp_prg_loader_pkg.sv - shared types and constants for the UDP program loader
package udp_prg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_LOAD,
    ST_CSUM
  } state_t;

  localparam logic [1:0] ERR_MAGIC = 2'd0;
  localparam logic [1:0] ERR_ALIGN = 2'd1;
  localparam logic [1:0] ERR_LEN   = 2'd2;
  localparam logic [1:0] ERR_CSUM  = 2'd3;

  localparam logic [31:0] DEF_MAGIC = 32'h5256_3332;

  localparam int unsigned HDR_MAGIC   = 0;
  localparam int unsigned HDR_BASE    = 1;
  localparam int unsigned HDR_COUNT   = 2;
  localparam int unsigned HDR_PAYLOAD = 3;

endpackage

// File: rtl/udp_prg_loader.sv
// rtl/udp_prg_loader.sv - streams a received program image from the UDP word buffer into imem
module udp_prg_loader
  import udp_prg_pkg::*;
#(
  parameter int          BUF_AW  = 9,
  parameter int          IMEM_AW = 12,
  parameter logic [31:0] MAGIC   = DEF_MAGIC
) (
  input  logic               E_RXC,
  input  logic               rst,
  input  logic               start,
  output logic               buf_rd_en,
  output logic [BUF_AW-1:0]  buf_rd_addr,
  input  logic [31:0]        buf_rd_data,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [31:0]        imem_wdata,
  output logic               cpu_run,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [1:0]         err_code
);

  localparam logic [31:0]       LEN_MAX   = 32'((64'd1 << BUF_AW) - 64'd4);
  localparam logic [BUF_AW-1:0] A_MAGIC   = BUF_AW'(HDR_MAGIC);
  localparam logic [BUF_AW-1:0] A_BASE    = BUF_AW'(HDR_BASE);
  localparam logic [BUF_AW-1:0] A_COUNT   = BUF_AW'(HDR_COUNT);
  localparam logic [BUF_AW-1:0] A_PAYLOAD = BUF_AW'(HDR_PAYLOAD);
  localparam logic [BUF_AW-1:0] ONE       = BUF_AW'(1);

  state_t               state;
  logic                 rd_valid;
  logic [BUF_AW-1:0]    rd_addr_q;
  logic [BUF_AW-1:0]    n_words;
  logic [BUF_AW-1:0]    pay_cnt;
  logic [BUF_AW-1:0]    last_addr;
  logic [IMEM_AW-1:0]   base_word;
  logic [31:0]          acc;
  logic                 chk_fail;
  logic [1:0]           chk_code;

  assign last_addr = n_words + A_PAYLOAD;

  // Every check is evaluated on the cycle its word is on buf_rd_data.
  always_comb begin
    chk_fail = 1'b0;
    chk_code = ERR_MAGIC;
    if (rd_valid) begin
      if (state == ST_HDR) begin
        if (rd_addr_q == A_MAGIC && buf_rd_data != MAGIC) begin
          chk_fail = 1'b1;
          chk_code = ERR_MAGIC;
        end else if (rd_addr_q == A_BASE && buf_rd_data[1:0] != 2'b00) begin
          chk_fail = 1'b1;
          chk_code = ERR_ALIGN;
        end else if (rd_addr_q == A_COUNT &&
                     (buf_rd_data == 32'd0 || buf_rd_data > LEN_MAX)) begin
          chk_fail = 1'b1;
          chk_code = ERR_LEN;
        end
      end else if (state == ST_CSUM && buf_rd_data != acc) begin
        chk_fail = 1'b1;
        chk_code = ERR_CSUM;
      end
    end
  end

  always_ff @(posedge E_RXC) begin
    if (!rst) begin
      state       <= ST_IDLE;
      rd_valid    <= 1'b0;
      rd_addr_q   <= '0;
      n_words     <= '0;
      pay_cnt     <= '0;
      base_word   <= '0;
      acc         <= '0;
      buf_rd_en   <= 1'b0;
      buf_rd_addr <= '0;
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= '0;
      cpu_run     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      err_code    <= ERR_MAGIC;
    end else begin
      done      <= 1'b0;
      error     <= 1'b0;
      imem_we   <= 1'b0;
      rd_valid  <= buf_rd_en;
      rd_addr_q <= buf_rd_addr;

      // Header reads (and the first payload read) go out before N is known;
      // a bad N aborts the stream anyway.
      if (buf_rd_en) begin
        if (buf_rd_addr <= A_PAYLOAD) begin
          buf_rd_addr <= buf_rd_addr + ONE;
        end else if (buf_rd_addr == last_addr) begin
          buf_rd_en <= 1'b0;
        end else begin
          buf_rd_addr <= buf_rd_addr + ONE;
        end
      end

      case (state)
        ST_IDLE: begin
          if (start && !done && !error) begin
            state       <= ST_HDR;
            busy        <= 1'b1;
            cpu_run     <= 1'b0;
            acc         <= '0;
            pay_cnt     <= '0;
            err_code    <= ERR_MAGIC;
            buf_rd_en   <= 1'b1;
            buf_rd_addr <= '0;
            rd_valid    <= 1'b0;
          end
        end
        ST_HDR: begin
          if (rd_valid) begin
            if (rd_addr_q == A_BASE) begin
              base_word <= buf_rd_data[IMEM_AW+1:2];
            end
            if (rd_addr_q == A_COUNT) begin
              n_words <= buf_rd_data[BUF_AW-1:0];
              state   <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          if (rd_valid) begin
            imem_we    <= 1'b1;
            imem_addr  <= base_word + IMEM_AW'(pay_cnt);
            imem_wdata <= buf_rd_data;
            acc        <= acc + buf_rd_data;
            pay_cnt    <= pay_cnt + ONE;
            if (pay_cnt == n_words - ONE) begin
              state <= ST_CSUM;
            end
          end
        end
        ST_CSUM: begin
          if (rd_valid && !chk_fail) begin
            done    <= 1'b1;
            cpu_run <= 1'b1;
            busy    <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // Abort drops the stream and discards anything still in flight.
      if (chk_fail) begin
        error     <= 1'b1;
        err_code  <= chk_code;
        state     <= ST_IDLE;
        busy      <= 1'b0;
        buf_rd_en <= 1'b0;
        rd_valid  <= 1'b0;
      end
    end
  end

endmodule

// File: doc/udp_prg_loader.md
# udp_prg_loader

Downstream consumer of the UDP receive word buffer. After a packet has been captured and `rx_finish` pulses, this block streams the buffered 32-bit words out at one word per cycle. It parses a small program header, writes the payload into the RV32 instruction memory, and checks a trailing checksum. It holds the CPU in reset for the whole load and releases it only after a verified load.

## Interface
Parameters:
- `BUF_AW`, 9: word-buffer address width (512 words).
- `IMEM_AW`, 12: instruction-memory word-address width.
- `MAGIC`, 32'h5256_3332: required header word 0 ("RV32").

Ports:
- `E_RXC`  in  1: sole clock; all logic on rising edge.
- `rst`  in  1: reset, synchronous, active-low.
- `start`  in  1: one-cycle pulse (`rx_finish`); a packet is complete in the buffer.
- `buf_rd_en`  out  1: buffer read strobe.
- `buf_rd_addr`  out  BUF_AW: buffer word address.
- `buf_rd_data`  in  32: buffer read data, valid exactly 1 cycle after `buf_rd_en`.
- `imem_we`  out  1: instruction-memory write strobe.
- `imem_addr`  out  IMEM_AW: instruction-memory word address.
- `imem_wdata`  out  32: instruction word.
- `cpu_run`  out  1: 1 = CPU released; 0 = CPU held in reset.
- `busy`  out  1: load in progress.
- `done`  out  1: one-cycle pulse, load verified.
- `error`  out  1: one-cycle pulse, load aborted or failed.
- `err_code`  out  2: 0 = bad magic, 1 = misaligned base, 2 = bad length, 3 = checksum mismatch. Valid with `error`, held until next accepted `start`.

## Operation
- Buffer layout by word address:
  - w0: `MAGIC`.
  - w1: base byte address.
  - w2: word count N.
  - w3 .. w(2+N): payload.
  - w(3+N): checksum, the 32-bit wrap-around sum of the payload words.
- States:
  - IDLE: on `start`, go to HDR. Clear `cpu_run`, assert `busy`, zero the checksum accumulator.
  - HDR: read w0..w2 back-to-back.
  - LOAD: read payload words.
  - CSUM: read w(3+N).
  - Return to IDLE with a `done` or `error` pulse.
- Header checks, each on the cycle its data arrives:
  - w0 != MAGIC gives code 0.
  - w1[1:0] != 0 gives code 1.
  - N == 0 or N > 2^BUF_AW − 4 gives code 2.
- Abort rule: on the first failed check, `error` pulses the next cycle. On that same cycle `buf_rd_en` drops, the state returns to IDLE and `busy` drops. Read data already in flight is discarded and no `imem_we` is issued.
- Payload write: payload word i goes to `imem_addr` = w1[IMEM_AW+1:2] + i, computed modulo 2^IMEM_AW. Wrap-around is silent.
- Checksum accumulator: 32-bit sum of all payload words, overflow discarded. A mismatch against w(3+N) gives `error` with code 3.
- On `error`, `cpu_run` stays 0. On `done`, `cpu_run` goes 1 the same cycle and stays 1 until the next accepted `start`.
- `start` while `busy`: ignored, with no effect on the load in progress.
- Reset mid-load: all state and outputs return to reset values next edge. A partially written imem is left as is; `cpu_run` = 0.

## Timing
- Reset values: `buf_rd_en`=0, `buf_rd_addr`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `cpu_run`=0, `busy`=0, `done`=0, `error`=0, `err_code`=0.
- Cycle numbering: the cycle where `start` is sampled is cycle 0. `busy`=1 from cycle 1.
- Reads: address a is issued in cycle 1+a with no bubbles, and its data arrives in cycle 2+a.
- Writes: all imem outputs are registered. Payload word i is written with `imem_we`=1 in cycle 6+i.
- `done` or `error` (code 3) pulses in cycle 6+N. `busy` is 0 from that cycle.
- Header-fail `error` timing: code 0 in cycle 3, code 1 in cycle 4, code 2 in cycle 5.
- Earliest accepted re-`start` is the cycle after `done` or `error`.

## Structure
- Package `udp_prg_pkg` holds:
  - the state enum (IDLE, HDR, LOAD, CSUM);
  - the error-code constants;
  - the default `MAGIC`;
  - the header word offsets (0, 1, 2, payload base 3).
- No sub-module: one FSM, a read-address counter, a payload counter, the accumulator and the output registers.

## Test plan
- Nominal load: w0=MAGIC, w1=0x100, w2=2, w3=0x00000013, w4=0x00100093, w5=0x001000A6, then `start`. Expect imem writes 0x040←0x00000013 in cycle 6 and 0x041←0x00100093 in cycle 7, `done` in cycle 8, `cpu_run`=1 from cycle 8.
- Bad magic: w0=0xDEADBEEF. Expect `error` with code 0 in cycle 3, no `imem_we`, `cpu_run`=0.
- Misaligned base and length limits: w1=0x102 gives code 1 in cycle 4. w2=0 and w2=509 each give code 2 in cycle 5. w2=508 loads fully.
- Checksum mismatch: nominal packet with w5=0x001000A7. Expect both imem writes, `error` with code 3 in cycle 8, `cpu_run` stays 0.
- Address wrap: w1=0x3FFC, N=2. Expect imem writes at 0xFFF then 0x000.
- Robustness: `start` re-pulsed in cycle 5 of the nominal load has no effect. `rst` low in cycle 6 returns all outputs to reset values next edge, and a fresh nominal load then succeeds.
